flag_branch_unit: RTL and testbench
===================================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: ex_vld  input  1  EX-stage instruction valid (not a bubble).
REQ-004: ex_opcode  input  4  EX-stage opcode.
REQ-005: ex_flag  input  3  ALU flags from EX, {N,V,Z}.
REQ-006: ex_stall  input  1  downstream freeze; the EX instruction does not advance this cycle.
REQ-007: id_br_vld  input  1  ID stage holds a conditional branch (B or BR).
REQ-008: id_ccc  input  3  branch condition code.
REQ-009: flush  input  1  squash the ID-stage branch this cycle.
REQ-010: br_taken  output  1  branch resolved taken this cycle.
REQ-011: br_stall  output  1  hold IF/ID and inject an EX bubble.
REQ-012: flag_q  output  3  committed flag register, {N,V,Z}.

Function
REQ-013: A flag writer is an EX instruction with ex_vld=1 and ex_stall=0.
REQ-014: ADD (0000) and SUB (0001) shall write N, V and Z from ex_flag.
REQ-015: XOR (0010), SLL (0100), SRA (0101) and ROR (0110) shall write Z only; N and V shall hold.
REQ-016: All other opcodes shall leave flag_q unchanged.
REQ-017: flag_q shall update one clk edge after the flag writer is presented.
REQ-018: ccc decode shall be: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&N=0; 011 LT N=1; 100 GE Z=1|N=0; 101 LE N=1|Z=1; 110 OV V=1; 111 always.
REQ-019: The FSM shall have two states, RESOLVE and HOLD.
REQ-020: In RESOLVE, when id_br_vld=1 and no flag hazard exists, br_taken shall be the condition result, combinational in the same cycle, with br_stall=0.
REQ-021: A flag hazard exists when EX holds a flag-writing opcode with ex_vld=1, or when ex_stall=1 with a flag-writing opcode valid in EX.
REQ-022: On a hazard without bypass, the unit shall assert br_stall=1 and br_taken=0, and shall move to HOLD at the next edge once ex_stall=0.
REQ-023: In HOLD, br_stall=0 and br_taken shall be evaluated from the freshly written flag_q; the state shall return to RESOLVE at the next edge.
REQ-024: A ccc of 111 never hazards: br_taken=1 immediately and br_stall=0.
REQ-025: flush=1 shall force br_taken=0 and br_stall=0, and the state shall return to RESOLVE at the next edge, overriding all other conditions.
REQ-026: When id_br_vld=0, br_taken=0 and br_stall=0.
REQ-027: br_taken and br_stall shall never both be 1.

Reset
REQ-028: rst=1 at an edge shall set flag_q=3'b000 and state=RESOLVE; while rst=1, br_taken=0 and br_stall=0.
REQ-029: A reset during HOLD shall abandon the pending branch; no taken pulse shall be emitted after reset.
REQ-030: Reset shall have priority over flush and over any flag write in the same edge.

Configuration
REQ-031: Macro FLAG_BYPASS_EN.
REQ-032: When FLAG_BYPASS_EN is defined, a hazard with ex_stall=0 shall resolve the branch in the same cycle using merged flags (the ex_flag fields the opcode writes, plus the remaining flag_q fields), with no stall and no HOLD.
REQ-033: When FLAG_BYPASS_EN is defined and ex_stall=1, the unit shall still stall.
REQ-034: When FLAG_BYPASS_EN is undefined, REQ-022 and REQ-023 govern.

Structure
REQ-035: The opcode constants, the ccc encodings, the {N,V,Z} bit indices and the FSM state encoding shall live in the shared ISA package.
REQ-036: A combinational sub-module cond_eval (inputs ccc and flags {N,V,Z}; output taken) shall be instantiated once.

Verification
REQ-037: Reset, then ADD with ex_flag=3'b100 -> flag_q=3'b100 one cycle later.
REQ-038: flag_q=3'b111, then XOR with ex_flag=3'b000 -> flag_q=3'b110 (N,V held).
REQ-039: Bypass off: SUB with ex_flag=001 in EX plus EQ branch in ID -> br_stall=1 for one cycle, then br_taken=1 in HOLD, then RESOLVE.
REQ-040: Bypass on: the same stimulus as REQ-039 -> br_taken=1 the same cycle, br_stall=0.
REQ-041: flush asserted while in HOLD -> br_taken=0 and state=RESOLVE next cycle; ccc=111 with ADD in EX -> br_taken=1 with no stall.
REQ-042: rst=1 during HOLD -> flag_q=000, no br_taken pulse; ex_stall=1 held 3 cycles with SUB in EX -> br_stall stays 1 and flag_q stays unchanged throughout.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared ISA definitions for the flag/branch unit: opcodes, condition codes,
// {N,V,Z} bit positions and FSM state encoding.
package flag_branch_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  localparam logic [2:0] CCC_NE = 3'b000;
  localparam logic [2:0] CCC_EQ = 3'b001;
  localparam logic [2:0] CCC_GT = 3'b010;
  localparam logic [2:0] CCC_LT = 3'b011;
  localparam logic [2:0] CCC_GE = 3'b100;
  localparam logic [2:0] CCC_LE = 3'b101;
  localparam logic [2:0] CCC_OV = 3'b110;
  localparam logic [2:0] CCC_AL = 3'b111;

  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic {
    ST_RESOLVE = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  function automatic logic writes_nvz(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_z_only(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational branch-condition evaluator over a {N,V,Z} flag vector.
module cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic w_n, w_v, w_z;

  assign w_n = flags[FLAG_N];
  assign w_v = flags[FLAG_V];
  assign w_z = flags[FLAG_Z];

  always_comb begin
    taken = 1'b0;
    case (ccc)
      CCC_NE:  taken = ~w_z;
      CCC_EQ:  taken = w_z;
      CCC_GT:  taken = ~w_z & ~w_n;
      CCC_LT:  taken = w_n;
      CCC_GE:  taken = w_z | ~w_n;
      CCC_LE:  taken = w_n | w_z;
      CCC_OV:  taken = w_v;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register and conditional-branch resolution with RESOLVE/HOLD interlock.
// Define FLAG_BYPASS_EN to resolve flag hazards in the same cycle from merged EX flags.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_vld,
  input  logic [3:0] ex_opcode,
  input  logic [2:0] ex_flag,
  input  logic       ex_stall,
  input  logic       id_br_vld,
  input  logic [2:0] id_ccc,
  input  logic       flush,
  output logic       br_taken,
  output logic       br_stall,
  output logic [2:0] flag_q
);

  logic       w_wr_nvz, w_wr_z, w_writer, w_hazard, w_cond;
  logic [2:0] r_flag, w_flag_d, w_eval_flags;
  state_t     r_state, w_state_d;

  assign w_wr_nvz = writes_nvz(ex_opcode);
  assign w_wr_z   = writes_z_only(ex_opcode);
  assign w_writer = ex_vld & ~ex_stall;
  assign w_hazard = ex_vld & (w_wr_nvz | w_wr_z);
  assign flag_q   = r_flag;

  // Next flag value doubles as the merged bypass view of the flags.
  always_comb begin
    w_flag_d = r_flag;
    if (w_writer) begin
      if (w_wr_nvz)
        w_flag_d = ex_flag;
      else if (w_wr_z)
        w_flag_d[FLAG_Z] = ex_flag[FLAG_Z];
    end
  end

`ifdef FLAG_BYPASS_EN
  assign w_eval_flags = (r_state == ST_RESOLVE) ? w_flag_d : r_flag;
`else
  assign w_eval_flags = r_flag;
`endif

  cond_eval u_cond_eval (
    .ccc   (id_ccc),
    .flags (w_eval_flags),
    .taken (w_cond)
  );

  always_comb begin
    w_state_d = r_state;
    br_taken  = 1'b0;
    br_stall  = 1'b0;
    if (rst || flush) begin
      w_state_d = ST_RESOLVE;
    end else begin
      case (r_state)
        ST_RESOLVE: begin
          if (id_br_vld) begin
            if (id_ccc == CCC_AL) begin
              br_taken = 1'b1;
            end else if (w_hazard) begin
`ifdef FLAG_BYPASS_EN
              if (!ex_stall)
                br_taken = w_cond;
              else
                br_stall = 1'b1;
`else
              br_stall = 1'b1;
              if (!ex_stall)
                w_state_d = ST_HOLD;
`endif
            end else begin
              br_taken = w_cond;
            end
          end
        end
        ST_HOLD: begin
          w_state_d = ST_RESOLVE;
          br_taken  = id_br_vld & w_cond;
        end
        default: w_state_d = ST_RESOLVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag  <= '0;
      r_state <= ST_RESOLVE;
    end else begin
      r_flag  <= w_flag_d;
      r_state <= w_state_d;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit; expectations follow FLAG_BYPASS_EN.
module tb_flag_branch_unit;

`ifdef FLAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0010, AND = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRA = 4'b0101, ROR = 4'b0110, NOP = 4'b1000;
  localparam logic [2:0] NE = 3'd0, EQ = 3'd1, LT = 3'd3, AL = 3'd7;

  logic       clk, rst, ex_vld, ex_stall, id_br_vld, flush;
  logic [3:0] ex_opcode;
  logic [2:0] ex_flag, id_ccc;
  logic       br_taken, br_stall;
  logic [2:0] flag_q;

  flag_branch_unit dut (
    .clk(clk), .rst(rst), .ex_vld(ex_vld), .ex_opcode(ex_opcode),
    .ex_flag(ex_flag), .ex_stall(ex_stall), .id_br_vld(id_br_vld),
    .id_ccc(id_ccc), .flush(flush), .br_taken(br_taken),
    .br_stall(br_stall), .flag_q(flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit r, v, st, bv, fl, et, es;
    logic [3:0] op;
    logic [2:0] f, c;
  } row_t;

  logic [4:0] sb[$];
  logic [4:0] e;
  logic [2:0] m_fq;
  int total = 0;
  int bad   = 0;
  row_t rows[$];

  function automatic row_t mk(bit r, bit v, logic [3:0] op, logic [2:0] f, bit st,
                              bit bv, logic [2:0] c, bit fl, bit et, bit es);
    row_t w;
    w.r = r; w.v = v; w.op = op; w.f = f; w.st = st;
    w.bv = bv; w.c = c; w.fl = fl; w.et = et; w.es = es;
    return w;
  endfunction

  // Reference condition table over {N,V,Z}.
  function automatic bit cond_ref(logic [2:0] c, logic [2:0] nvz);
    bit n, v, z;
    n = nvz[2]; v = nvz[1]; z = nvz[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive(row_t w);
    rst = w.r; ex_vld = w.v; ex_opcode = w.op; ex_flag = w.f; ex_stall = w.st;
    id_br_vld = w.bv; id_ccc = w.c; flush = w.fl;
    sb.push_back({w.et, w.es, m_fq});
    if (w.r)
      m_fq = 3'b000;
    else if (w.v && !w.st) begin
      if (w.op == ADD || w.op == SUB)
        m_fq = w.f;
      else if (w.op == XOR || w.op == SLL || w.op == SRA || w.op == ROR)
        m_fq[0] = w.f[0];
    end
  endtask

  task automatic test_reset;
    rows.delete();
    rows.push_back(mk(H, H, ADD, 3'b111, L, H, AL, L, L, L));
    rows.push_back(mk(H, L, ADD, 3'b000, L, H, NE, H, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, NE, L, L, L));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL reset[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_flag_write;
    rows.delete();
    rows.push_back(mk(L, H, ADD, 3'b100, L, L, NE, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, ADD, 3'b111, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, XOR, 3'b000, L, L, NE, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, AND, 3'b001, L, L, NE, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b001, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, SLL, 3'b001, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, SRA, 3'b000, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, ROR, 3'b001, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, SUB, 3'b010, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, NOP, 3'b101, L, L, NE, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, NE, L, L, L));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL flag_write[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_cond;
    logic [2:0] fv[5];
    fv[0] = 3'b111; fv[1] = 3'b000; fv[2] = 3'b010; fv[3] = 3'b100; fv[4] = 3'b001;
    rows.delete();
    for (int k = 0; k < 5; k++) begin
      rows.push_back(mk(L, H, ADD, fv[k], L, L, NE, L, L, L));
      for (int c = 0; c < 8; c++)
        rows.push_back(mk(L, L, ADD, 3'b000, L, H, 3'(c), L, cond_ref(3'(c), fv[k]), L));
      rows.push_back(mk(L, H, AND, ~fv[k], L, H, EQ, L, cond_ref(EQ, fv[k]), L));
    end
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL cond[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_hazard;
    rows.delete();
    rows.push_back(mk(L, H, ADD, 3'b000, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, SUB, 3'b001, L, H, EQ, L, BYP, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, !BYP, EQ, L, !BYP, L));
    rows.push_back(mk(L, H, XOR, 3'b000, L, H, EQ, L, L, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, !BYP, EQ, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, H, NE, L, H, L));
    rows.push_back(mk(L, H, SRA, 3'b110, L, H, LT, L, L, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, !BYP, LT, L, L, L));
    rows.push_back(mk(L, H, ROR, 3'b001, L, H, EQ, L, BYP, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, !BYP, EQ, L, !BYP, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, NE, L, L, L));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL hazard[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_ex_stall;
    rows.delete();
    rows.push_back(mk(L, H, SUB, 3'b111, H, H, EQ, H, L, L));
    for (int k = 0; k < 3; k++)
      rows.push_back(mk(L, H, SUB, 3'b111, H, H, EQ, L, L, H));
    rows.push_back(mk(L, H, SUB, 3'b111, L, H, EQ, L, BYP, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, !BYP, EQ, L, !BYP, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, EQ, L, L, L));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL ex_stall[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_flush_always;
    rows.delete();
    rows.push_back(mk(L, H, ADD, 3'b000, L, H, NE, L, BYP, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, H, NE, H, L, L));
    rows.push_back(mk(L, H, XOR, 3'b001, L, H, NE, L, L, !BYP));
    rows.push_back(mk(L, L, ADD, 3'b000, L, !BYP, NE, L, L, L));
    rows.push_back(mk(L, H, ADD, 3'b111, L, H, EQ, H, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, H, EQ, L, H, L));
    rows.push_back(mk(L, H, ADD, 3'b000, L, H, AL, L, H, L));
    rows.push_back(mk(L, H, ADD, 3'b001, L, L, NE, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, L, NE, L, L, L));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL flush_always[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_reset_in_hold;
    rows.delete();
    rows.push_back(mk(L, H, ADD, 3'b000, L, L, NE, L, L, L));
    rows.push_back(mk(L, H, SUB, 3'b001, L, H, EQ, L, BYP, !BYP));
    rows.push_back(mk(H, L, ADD, 3'b000, L, H, EQ, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, H, EQ, L, L, L));
    rows.push_back(mk(L, L, ADD, 3'b000, L, H, NE, L, H, L));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i]);
      @(negedge clk); e = sb.pop_front(); total++;
      if ({br_taken, br_stall, flag_q} !== e) begin
        bad++;
        $display("FAIL reset_in_hold[%0d] got t/s/fq=%b/%b/%b need %b/%b/%b", i, br_taken, br_stall, flag_q, e[4], e[3], e[2:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ex_vld = 1'b0; ex_opcode = 4'b0000; ex_flag = 3'b000;
    ex_stall = 1'b0; id_br_vld = 1'b0; id_ccc = 3'b000; flush = 1'b0;
    m_fq = 3'b000;
    repeat (2) @(posedge clk);
    test_reset();
    test_flag_write();
    test_cond();
    test_hazard();
    test_ex_stall();
    test_flush_always();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
